// File: rtl/neurosync_round_engine_if.sv
// NeuroSync round engine bus: question memory port plus the
// play-analyser / range-meter handshakes and servo controls.
interface neurosync_round_engine_if #(
    parameter int ADDR_W = 3,
    parameter int WORD_W = 60
);
    logic [ADDR_W+1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic              pronto_play;
    logic              acertou_play;
    logic              pronto_faixa;
    logic              acertou_faixa;
    logic [WORD_W-1:0] palavra;
    logic              set_pos;
    logic              jogando;
    logic              medir;

    modport master (
        output mem_addr,
        input  mem_data,
        input  pronto_play,
        input  acertou_play,
        input  pronto_faixa,
        input  acertou_faixa,
        output palavra,
        output set_pos,
        output jogando,
        output medir
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        output pronto_play,
        output acertou_play,
        output pronto_faixa,
        output acertou_faixa,
        input  palavra,
        input  set_pos,
        input  jogando,
        input  medir
    );
endinterface

// File: rtl/neurosync_round_engine.sv
// NeuroSync round sequencer: fetches questions, dispatches them to the
// play analyser or range meter, and keeps per-player saturating scores.
module neurosync_round_engine #(
    parameter int N_PERGUNTAS    = 8,
    parameter int ADDR_W         = 3,
    parameter int N_JOGADORES    = 2,
    parameter int JOG_W          = 1,
    parameter int SCORE_W        = 4,
    parameter int WORD_W         = 60,
    parameter int TIMEOUT_CICLOS = 50000000,
    parameter int TMO_W          = 26
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic [1:0]                     modo,
    neurosync_round_engine_if.master       bus,
    output logic [ADDR_W-1:0]              indice,
    output logic [JOG_W-1:0]               jogador,
    output logic [N_JOGADORES*SCORE_W-1:0] pontos,
    output logic                           acertou,
    output logic                           timeout,
    output logic                           fim_jogo,
    output logic [3:0]                     db_estado
);

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        REGISTRA  = 4'd1,
        BUSCA     = 4'd2,
        CARREGA   = 4'd3,
        POSICIONA = 4'd4,
        ESPERA    = 4'd5,
        AVALIA    = 4'd6,
        PROXIMO   = 4'd7,
        FIM       = 4'd8
    } estado_t;

    localparam logic [ADDR_W-1:0] ULTIMA   = ADDR_W'(N_PERGUNTAS - 1);
    localparam logic [JOG_W-1:0]  ULT_JOG  = JOG_W'(N_JOGADORES - 1);
    localparam logic [TMO_W-1:0]  TMO_LIM  = TMO_W'(TIMEOUT_CICLOS - 1);
    localparam logic [SCORE_W-1:0] PTS_MAX = '1;

    estado_t                          estado_q, estado_d;
    logic                             iniciar_q, iniciar_d;
    logic [1:0]                       modo_q, modo_d;
    logic [ADDR_W-1:0]                indice_q, indice_d;
    logic [JOG_W-1:0]                 jogador_q, jogador_d;
    logic [N_JOGADORES*SCORE_W-1:0]   pontos_q, pontos_d;
    logic [WORD_W-1:0]                palavra_q, palavra_d;
    logic [TMO_W-1:0]                 cnt_q, cnt_d;
    logic                             hit_q, hit_d;
    logic                             tmo_q, tmo_d;

    logic                             faixa;
    logic                             pronto_sel;
    logic                             acertou_sel;
    logic [SCORE_W-1:0]               pts_atual;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            iniciar_q <= 1'b0;
            modo_q    <= '0;
            indice_q  <= '0;
            jogador_q <= '0;
            pontos_q  <= '0;
            palavra_q <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            iniciar_q <= iniciar_d;
            modo_q    <= modo_d;
            indice_q  <= indice_d;
            jogador_q <= jogador_d;
            pontos_q  <= pontos_d;
            palavra_q <= palavra_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            tmo_q     <= tmo_d;
        end
    end

    // Opcode 2'b11 routes the question to the range meter
    assign faixa       = (palavra_q[WORD_W-1 -: 2] == 2'b11);
    assign pronto_sel  = faixa ? bus.pronto_faixa : bus.pronto_play;
    assign acertou_sel = faixa ? bus.acertou_faixa : bus.acertou_play;
    assign pts_atual   = pontos_q[jogador_q*SCORE_W +: SCORE_W];

    always_comb begin
        estado_d  = estado_q;
        iniciar_d = iniciar;
        modo_d    = modo_q;
        indice_d  = indice_q;
        jogador_d = jogador_q;
        pontos_d  = pontos_q;
        palavra_d = palavra_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        tmo_d     = tmo_q;

        unique case (estado_q)
            OCIOSO: begin
                if (iniciar && !iniciar_q) estado_d = REGISTRA;
            end
            REGISTRA: begin
                modo_d    = modo;
                pontos_d  = '0;
                indice_d  = '0;
                jogador_d = '0;
                estado_d  = BUSCA;
            end
            BUSCA: estado_d = CARREGA;
            CARREGA: begin
                palavra_d = bus.mem_data;
                estado_d  = POSICIONA;
            end
            POSICIONA: begin
                cnt_d    = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                cnt_d = cnt_q + TMO_W'(1);
                // A result arriving on the last allowed cycle beats the timeout
                if (pronto_sel) begin
                    hit_d    = acertou_sel;
                    tmo_d    = 1'b0;
                    estado_d = AVALIA;
                end else if (cnt_q == TMO_LIM) begin
                    hit_d    = 1'b0;
                    tmo_d    = 1'b1;
                    estado_d = AVALIA;
                end
            end
            AVALIA: begin
                if (hit_q && (pts_atual != PTS_MAX))
                    pontos_d[jogador_q*SCORE_W +: SCORE_W] = pts_atual + SCORE_W'(1);
                estado_d = (indice_q == ULTIMA) ? FIM : PROXIMO;
            end
            PROXIMO: begin
                indice_d  = indice_q + ADDR_W'(1);
                jogador_d = (jogador_q == ULT_JOG) ? '0 : jogador_q + JOG_W'(1);
                estado_d  = BUSCA;
            end
            FIM: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    assign bus.mem_addr = {modo_q, indice_q};
    assign bus.palavra  = palavra_q;
    assign bus.set_pos  = (estado_q == POSICIONA);
    assign bus.jogando  = (estado_q == ESPERA) && !faixa;
    assign bus.medir    = (estado_q == ESPERA) && faixa;

    assign indice    = indice_q;
    assign jogador   = jogador_q;
    assign pontos    = pontos_q;
    assign acertou   = (estado_q == AVALIA) && hit_q;
    assign timeout   = (estado_q == AVALIA) && tmo_q;
    assign fim_jogo  = (estado_q == FIM);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_neurosync_round_engine.sv
// Directed bench for neurosync_round_engine: two-player game with a short
// timeout, and a one-player build with a 2-bit saturating score.
module tb_neurosync_round_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ini_a, ini_b;
    logic [1:0]  modo_a, modo_b;
    logic [59:0] mem [0:31];

    logic [2:0] ind_a, ind_b;
    logic [0:0] jog_a, jog_b;
    logic [7:0] pts_a;
    logic [1:0] pts_b;
    logic       ac_a, to_a, fim_a, ac_b, to_b, fim_b;
    logic [3:0] st_a, st_b;

    int n_chk = 0;
    int n_err = 0;

    neurosync_round_engine_if #(.ADDR_W(3), .WORD_W(60)) ifa ();
    neurosync_round_engine_if #(.ADDR_W(3), .WORD_W(60)) ifb ();

    neurosync_round_engine #(
        .TIMEOUT_CICLOS(10), .TMO_W(4)
    ) dut_a (
        .clock(clk), .reset(rst_n), .iniciar(ini_a), .modo(modo_a),
        .bus(ifa), .indice(ind_a), .jogador(jog_a), .pontos(pts_a),
        .acertou(ac_a), .timeout(to_a), .fim_jogo(fim_a), .db_estado(st_a)
    );

    neurosync_round_engine #(
        .N_JOGADORES(1), .JOG_W(1), .SCORE_W(2),
        .TIMEOUT_CICLOS(10), .TMO_W(4)
    ) dut_b (
        .clock(clk), .reset(rst_n), .iniciar(ini_b), .modo(modo_b),
        .bus(ifb), .indice(ind_b), .jogador(jog_b), .pontos(pts_b),
        .acertou(ac_b), .timeout(to_b), .fim_jogo(fim_b), .db_estado(st_b)
    );

    always @(posedge clk) begin
        ifa.mem_data <= mem[ifa.mem_addr];
        ifb.mem_data <= mem[ifb.mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_a(input logic [3:0] s);
        int k = 0;
        while (st_a !== s && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (st_a !== s) chk("wait_a", {60'd0, st_a}, {60'd0, s});
    endtask

    task automatic wait_b(input logic [3:0] s);
        int k = 0;
        while (st_b !== s && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (st_b !== s) chk("wait_b", {60'd0, st_b}, {60'd0, s});
    endtask

    task automatic start_a(input logic [1:0] m);
        @(negedge clk);
        modo_a = m;
        ini_a  = 1'b1;
        @(negedge clk);
        ini_a  = 1'b0;
    endtask

    task automatic q_play(input logic [4:0] addr, input logic acc);
        wait_a(4'd2);
        chk("addr", 64'(ifa.mem_addr), 64'(addr));
        wait_a(4'd4);
        chk("set_pos", 64'(ifa.set_pos), 64'd1);
        chk("palavra", 64'(ifa.palavra), 64'(mem[addr]));
        wait_a(4'd5);
        chk("jogando", 64'(ifa.jogando), 64'd1);
        @(negedge clk);
        ifa.pronto_play  = 1'b1;
        ifa.acertou_play = acc;
        @(negedge clk);
        ifa.pronto_play  = 1'b0;
        ifa.acertou_play = 1'b0;
        chk("avalia", 64'(st_a), 64'd6);
        chk("acertou", 64'(ac_a), 64'(acc));
        chk("no_tmo", 64'(to_a), 64'd0);
    endtask

    initial begin
        logic [1:0] op;
        for (int i = 0; i < 32; i++) begin
            op = 2'(i % 3);
            mem[i] = {op, 58'(i * 1000 + 5)};
        end
        mem[11] = {2'b11, 58'd777};

        rst_n = 1'b0;
        ini_a = 1'b0; ini_b = 1'b0;
        modo_a = 2'd0; modo_b = 2'd0;
        ifa.pronto_play = 1'b0; ifa.acertou_play = 1'b0;
        ifa.pronto_faixa = 1'b0; ifa.acertou_faixa = 1'b0;
        ifb.pronto_play = 1'b0; ifb.acertou_play = 1'b0;
        ifb.pronto_faixa = 1'b0; ifb.acertou_faixa = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 64'(st_a), 64'd0);
        chk("rst_pontos", 64'(pts_a), 64'd0);
        chk("rst_addr", 64'(ifa.mem_addr), 64'd0);
        chk("rst_fim", 64'(fim_a), 64'd0);
        rst_n = 1'b1;

        // Game 1: bank 2, eight play hits, players alternate
        start_a(2'd2);
        for (int i = 0; i < 8; i++) q_play(5'(16 + i), 1'b1);
        @(negedge clk);
        chk("g1_fim", 64'(fim_a), 64'd1);
        chk("g1_state", 64'(st_a), 64'd8);
        chk("g1_pontos", 64'(pts_a), 64'h44);
        @(negedge clk);
        chk("g1_fim_off", 64'(fim_a), 64'd0);
        chk("g1_idle", 64'(st_a), 64'd0);

        // Game 2: bank 1 with timeout, coincident pronto and a range question
        start_a(2'd1);
        q_play(5'd8, 1'b1);
        wait_a(4'd2);
        chk("g2_addr1", 64'(ifa.mem_addr), 64'd9);
        wait_a(4'd5);
        repeat (9) @(negedge clk);
        chk("tmo_early_st", 64'(st_a), 64'd5);
        chk("tmo_early", 64'(to_a), 64'd0);
        @(negedge clk);
        chk("tmo_st", 64'(st_a), 64'd6);
        chk("tmo_pulse", 64'(to_a), 64'd1);
        chk("tmo_miss", 64'(ac_a), 64'd0);

        wait_a(4'd2);
        chk("g2_addr2", 64'(ifa.mem_addr), 64'd10);
        wait_a(4'd5);
        repeat (9) @(negedge clk);
        ifa.pronto_play  = 1'b1;
        ifa.acertou_play = 1'b1;
        @(negedge clk);
        ifa.pronto_play  = 1'b0;
        ifa.acertou_play = 1'b0;
        chk("coin_st", 64'(st_a), 64'd6);
        chk("coin_hit", 64'(ac_a), 64'd1);
        chk("coin_tmo", 64'(to_a), 64'd0);

        wait_a(4'd2);
        chk("g2_addr3", 64'(ifa.mem_addr), 64'd11);
        wait_a(4'd5);
        chk("faixa_medir", 64'(ifa.medir), 64'd1);
        chk("faixa_jog", 64'(ifa.jogando), 64'd0);
        chk("faixa_player", 64'(jog_a), 64'd1);
        ifa.pronto_play  = 1'b1;
        ifa.acertou_play = 1'b1;
        @(negedge clk);
        ifa.pronto_play  = 1'b0;
        ifa.acertou_play = 1'b0;
        chk("faixa_ignore", 64'(st_a), 64'd5);
        ifa.pronto_faixa  = 1'b1;
        ifa.acertou_faixa = 1'b0;
        @(negedge clk);
        ifa.pronto_faixa  = 1'b0;
        chk("faixa_st", 64'(st_a), 64'd6);
        chk("faixa_miss", 64'(ac_a), 64'd0);
        @(negedge clk);
        chk("faixa_pts", 64'(pts_a), 64'h02);
        for (int i = 4; i < 8; i++) q_play(5'(8 + i), 1'b1);
        @(negedge clk);
        chk("g2_fim", 64'(fim_a), 64'd1);
        chk("g2_pontos", 64'(pts_a), 64'h24);

        // Game 3: reset in the middle of a question
        start_a(2'd0);
        q_play(5'd0, 1'b1);
        wait_a(4'd5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_st", 64'(st_a), 64'd0);
        chk("mid_rst_pts", 64'(pts_a), 64'd0);
        chk("mid_rst_ctl", 64'({ifa.set_pos, ifa.jogando, ifa.medir,
                                ac_a, to_a, fim_a}), 64'd0);
        chk("mid_rst_idx", 64'({ind_a, jog_a}), 64'd0);
        chk("mid_rst_word", 64'(ifa.palavra), 64'd0);

        // One player, 2-bit score saturates at 3
        @(negedge clk);
        modo_b = 2'd2;
        ini_b  = 1'b1;
        @(negedge clk);
        ini_b  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            wait_b(4'd5);
            @(negedge clk);
            ifb.pronto_play  = 1'b1;
            ifb.acertou_play = 1'b1;
            @(negedge clk);
            ifb.pronto_play  = 1'b0;
            ifb.acertou_play = 1'b0;
            chk("b_avalia", 64'(st_b), 64'd6);
            chk("b_jog", 64'(jog_b), 64'd0);
            chk("b_pts", 64'(pts_b), (k - 1 > 3) ? 64'd3 : 64'(k - 1));
        end
        @(negedge clk);
        chk("b_fim", 64'(fim_b), 64'd1);
        chk("b_sat", 64'(pts_b), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
